add_sub_serial: RTL and testbench

Parametrised digit-serial adder/subtractor, the successor to the fixed 8-bit bit-serial adder. It processes DIGIT bits per cycle over WIDTH-bit operands. It has valid/ready handshakes on input and output, a per-transaction add/sub mode, and a carry/borrow output. It sits between register-file style producers and consumers in the datapath, wherever area matters more than latency.

---
 rtl/add_sub_serial.sv | 156 +++++++++++++++
 tb/tb_add_sub_serial.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/add_sub_serial.sv
// add_sub_serial: digit-serial adder/subtractor with valid/ready handshakes.
// Processes DIGIT bits per CALC cycle over WIDTH-bit operands. Subtract is
// a + ~b + 1, so carry_out = 1 means "no borrow" for a subtract.
// Optional feature macro: ADD_SERIAL_OVF_EN adds the signed-overflow output ovf.
module add_sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
`ifdef ADD_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             carry_out
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef ADD_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [DIGIT:0]   digit_sum_s;
    logic [WIDTH-1:0] digit_ext_s;

    // Next-state and datapath: one DIGIT-wide add per CALC cycle, LSB digit first.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        count_d     = count_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
`ifdef ADD_SERIAL_OVF_EN
        ovf_d       = ovf_q;
`endif
        digit_sum_s = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
        // The new digit enters at the MSB end while the result shifts right.
        digit_ext_s = WIDTH'(digit_sum_s[DIGIT-1:0]);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    count_d = {CW{1'b0}};
                    out_d   = {WIDTH{1'b0}};
`ifdef ADD_SERIAL_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                out_d   = (out_q >> DIGIT) | (digit_ext_s << (WIDTH - DIGIT));
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = digit_sum_s[DIGIT];
                if (count_q == CW'(STEPS - 1)) begin
                    // Final digit: hold count so it never wraps.
                    carry_out_d = digit_sum_s[DIGIT];
`ifdef ADD_SERIAL_OVF_EN
                    ovf_d = (a_q[DIGIT-1] == b_q[DIGIT-1])
                         && (digit_sum_s[DIGIT-1] != a_q[DIGIT-1]);
`endif
                    state_d = DONE;
                end else begin
                    count_d = count_q + CW'(1);
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            out_q       <= {WIDTH{1'b0}};
            count_q     <= {CW{1'b0}};
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ADD_SERIAL_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign carry_out = carry_out_q;
`ifdef ADD_SERIAL_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_add_sub_serial.sv
// tb_add_sub_serial: self-checking bench for add_sub_serial.
// Instance u0 is WIDTH=8/DIGIT=1, instance u1 is WIDTH=16/DIGIT=4.
// Expected results come from plain integer arithmetic on the operands.
module tb_add_sub_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv0 = 1'b0, ir0, s0 = 1'b0, ov0, or0 = 1'b1, c0;
    logic [7:0]  a0 = 8'h00, b0 = 8'h00, o0;
    logic        iv1 = 1'b0, ir1, s1 = 1'b0, ov1, or1 = 1'b1, c1;
    logic [15:0] a1 = 16'h0000, b1 = 16'h0000, o1;
`ifdef ADD_SERIAL_OVF_EN
    logic        f0, f1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add_sub_serial #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .sub(s0), .out_valid(ov0), .out_ready(or0),
        .out(o0),
`ifdef ADD_SERIAL_OVF_EN
        .ovf(f0),
`endif
        .carry_out(c0)
    );

    add_sub_serial #(.WIDTH(16), .DIGIT(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .sub(s1), .out_valid(ov1), .out_ready(or1),
        .out(o1),
`ifdef ADD_SERIAL_OVF_EN
        .ovf(f1),
`endif
        .carry_out(c1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: modular result, unsigned carry/no-borrow, signed overflow.
    task automatic model(input int w, input logic [15:0] x, input logic [15:0] y,
                         input logic s, output logic [15:0] r, output logic c,
                         output logic o);
        longint m, full, sx, sy, tr;
        m = longint'(1) << w;
        if (s) begin
            full = longint'(x) - longint'(y);
            c    = (x >= y);
        end else begin
            full = longint'(x) + longint'(y);
            c    = (full >= m);
        end
        r  = 16'(full & (m - 1));
        sx = x[w-1] ? longint'(x) - m : longint'(x);
        sy = y[w-1] ? longint'(y) - m : longint'(y);
        tr = s ? sx - sy : sx + sy;
        o  = (tr < -(m / 2)) || (tr >= (m / 2));
    endtask

    // One full transaction with out_ready held high; checks latency and results.
    task automatic do_txn(input bit which, input logic [15:0] ta, input logic [15:0] tbv,
                          input logic ts, input string tag);
        int          w, steps, lat;
        logic [15:0] mask, er;
        logic        ec, eo;
        w     = which ? 16 : 8;
        steps = which ? 4 : 8;
        mask  = which ? 16'hFFFF : 16'h00FF;
        ta    = ta & mask;
        tbv   = tbv & mask;
        model(w, ta, tbv, ts, er, ec, eo);
        or0 = 1'b1;
        or1 = 1'b1;
        if (which) begin
            a1 = ta; b1 = tbv; s1 = ts; iv1 = 1'b1;
        end else begin
            a0 = ta[7:0]; b0 = tbv[7:0]; s0 = ts; iv0 = 1'b1;
        end
        chk({tag, "_in_ready"}, 32'(which ? ir1 : ir0), 32'd1);
        @(posedge clk); #1;
        iv0 = 1'b0; iv1 = 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom); s0 = 1'($urandom);
        a1 = 16'($urandom); b1 = 16'($urandom); s1 = 1'($urandom);
        lat = 0;
        while (!(which ? ov1 : ov0) && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(steps));
        chk({tag, "_out"}, 32'(which ? o1 : {8'h00, o0}), 32'(er));
        chk({tag, "_carry"}, 32'(which ? c1 : c0), 32'(ec));
`ifdef ADD_SERIAL_OVF_EN
        chk({tag, "_ovf"}, 32'(which ? f1 : f0), 32'(eo));
`endif
        @(posedge clk); #1;
        chk({tag, "_back_idle_valid"}, 32'(which ? ov1 : ov0), 32'd0);
        chk({tag, "_back_idle_ready"}, 32'(which ? ir1 : ir0), 32'd1);
    endtask

    initial begin
        logic        stale;
        int          lat;

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready0", 32'(ir0), 32'd1);
        chk("rst_out_valid0", 32'(ov0), 32'd0);
        chk("rst_out0", 32'(o0), 32'd0);
        chk("rst_carry0", 32'(c0), 32'd0);
        chk("rst_in_ready1", 32'(ir1), 32'd1);
        chk("rst_out1", 32'(o1), 32'd0);

        // Directed cases from the examples.
        do_txn(1'b0, 16'h005A, 16'h0033, 1'b0, "add_5a_33");
        do_txn(1'b0, 16'h0010, 16'h0020, 1'b1, "sub_borrow");
        do_txn(1'b0, 16'h0020, 16'h0010, 1'b1, "sub_noborrow");
        do_txn(1'b0, 16'h00FF, 16'h0001, 1'b0, "add_wrap");
        do_txn(1'b0, 16'h007F, 16'h0001, 1'b0, "add_ovf");
        do_txn(1'b0, 16'h0080, 16'h0001, 1'b1, "sub_ovf");
        do_txn(1'b0, 16'h0055, 16'h0000, 1'b1, "sub_zero");
        do_txn(1'b1, 16'hFFFF, 16'h0001, 1'b0, "w16_wrap");
        do_txn(1'b1, 16'h1234, 16'h4321, 1'b1, "w16_sub");

        // Stall in DONE for 5 cycles with in_valid pulses that must be ignored.
        or0 = 1'b0;
        a0 = 8'h5A; b0 = 8'h33; s0 = 1'b0; iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        lat = 0;
        while (!ov0 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            iv0 = ~iv0;
            a0  = 8'($urandom);
            b0  = 8'($urandom);
            @(posedge clk); #1;
            chk("stall_valid", 32'(ov0), 32'd1);
            chk("stall_out", 32'(o0), 32'h8D);
            chk("stall_carry", 32'(c0), 32'd0);
            chk("stall_in_ready", 32'(ir0), 32'd0);
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", 32'(ov0), 32'd0);
        chk("stall_release_ready", 32'(ir0), 32'd1);
        do_txn(1'b0, 16'h00C3, 16'h003C, 1'b0, "after_stall");

        // Reset during the 4th CALC cycle discards the transaction.
        a0 = 8'h12; b0 = 8'h34; s0 = 1'b0; iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(ir0), 32'd1);
        chk("midrst_out_valid", 32'(ov0), 32'd0);
        chk("midrst_out", 32'(o0), 32'd0);
        chk("midrst_carry", 32'(c0), 32'd0);
        stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ov0) stale = 1'b1;
        end
        chk("midrst_no_stale", 32'(stale), 32'd0);
        do_txn(1'b0, 16'h0001, 16'h0002, 1'b1, "after_midrst");

        // Randomized transactions on both widths.
        for (int i = 0; i < 12; i++) begin
            do_txn(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), "rand8");
            do_txn(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), "rand16");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
